triangle_pixel_scanner: RTL
===========================

Name: triangle_pixel_scanner

Overview:
- Feeds `pixel_calculator` and writes its results back to the depth/colour buffer, i.e. the read-side driver and write-back sink of the calculator's pixel interface.
- Per accepted triangle: computes the screen-clipped bounding box, scans it row-major at one pixel/clock, and issues a buffer read per pixel.
- Presents each read word with its coordinates and the triangle to the calculator, then writes each returned pixel to the buffer.

Parameters:
- H_RES, 320, screen width in pixels (x range 0..H_RES-1)
- V_RES, 240, screen height in pixels (y range 0..V_RES-1)
- READ_LATENCY, 2, buffer read latency in clocks
- ADDR_WIDTH, 17, buffer address width; address = y*H_RES + x

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- triangle_in  in  128  color|p1x|p1y|p2x|p2y|p3x|p3y|depth; 16-bit fields, coordinates signed
- triangle_valid_in  in  1  triangle offered
- triangle_ready_out  out  1  high only in IDLE
- read_addr_out  out  ADDR_WIDTH  buffer read address
- read_en_out  out  1  read strobe
- read_data_in  in  32  colour[31:16]|depth[15:0], valid READ_LATENCY clocks after read_en_out
- calc_x_out  out  9  pixel x to calculator
- calc_y_out  out  8  pixel y to calculator
- calc_pixel_out  out  32  buffer word to calculator
- calc_triangle_out  out  128  latched triangle, constant for the whole job
- calc_valid_out  out  1  calculator input valid
- calc_x_in  in  9  calculator result x
- calc_y_in  in  8  calculator result y
- calc_pixel_in  in  32  calculator result word
- calc_valid_in  in  1  calculator result valid
- write_addr_out  out  ADDR_WIDTH  write-back address
- write_data_out  out  32  write-back word
- write_en_out  out  1  write strobe
- busy_out  out  1  high in all states except IDLE
- done_out  out  1  one-cycle pulse when a job's last write has issued

Behaviour:
- Reset values:
  - All outputs 0 except triangle_ready_out=1.
  - State IDLE.
  - Delay-line valids cleared.
  - Outstanding counter 0.
- States: IDLE -> SETUP -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Accept when triangle_valid_in && triangle_ready_out.
  - Latch triangle into calc_triangle_out; go to SETUP.
- SETUP (1 cycle): compute the bounding box.
  - xmin/xmax/ymin/ymax = signed min/max of the vertices.
  - Clip to [0,H_RES-1] and [0,V_RES-1].
  - Box empty (xmax<0, xmin>H_RES-1, ymax<0 or ymin>V_RES-1) -> DONE.
  - Otherwise -> SCAN with x=xmin, y=ymin.
- SCAN:
  - Each cycle: read_en_out=1, read_addr_out=y*H_RES+x.
  - Advance x; at xmax wrap x to xmin and increment y.
  - After issuing (xmax,ymax) -> DRAIN.
  - Reads never stall.
- Delay line:
  - (x,y,en) delayed exactly READ_LATENCY clocks.
  - calc_valid_out = delayed en; calc_x/y_out = delayed coordinates; calc_pixel_out = read_data_in, combinational pass-through on that cycle.
- Write-back:
  - On calc_valid_in, in the same cycle: write_en_out=1, write_addr_out=calc_y_in*H_RES+calc_x_in, write_data_out=calc_pixel_in.
  - write_en_out is 0 otherwise.
- Outstanding counter:
  - +1 per read issued, -1 per calc_valid_in; both in the same cycle leave it unchanged.
  - Width sized for H_RES*V_RES.
- DRAIN -> DONE when the counter is 0 and no read is issuing.
- DONE: done_out=1 for one cycle -> IDLE.
- triangle_ready_out returns high the cycle after done_out.
- Back-to-back triangles never overlap, so there is no read-after-write hazard across jobs.
- calc_valid_in outside a job is still written back and does not underflow the counter; the counter saturates at 0.
- Reset mid-job:
  - Next cycle: IDLE, all strobes 0, pending delay-line entries discarded.
  - No further writes from that job.
- Throughput: 1 pixel/clk. Job latency = area + READ_LATENCY + calculator latency (1) + 3 clocks.

Optional Feature:
- Macro: DEGENERATE_CULL_EN.
- When defined, SETUP also computes the 32-bit signed area term (p2x-p1x)*(p3y-p1y) - (p2y-p1y)*(p3x-p1x).
  - Zero -> go directly to DONE: no reads, no writes, done_out still pulses.
  - SETUP takes 2 cycles to register the product.
- When undefined, degenerate triangles are scanned normally and the calculator filters them.

Test Plan:
- Triangle (10,10),(12,10),(10,12), depth 5 -> 9 reads:
  - Addresses 3210-3212, 3530-3532, 3850-3852 in order.
  - calc_valid_out exactly 2 clocks after each read_en_out.
  - 9 writes to the same addresses, then one done_out pulse.
- Offscreen triangle (-50,-50),(-40,-50),(-50,-40) -> zero reads/writes; done_out 2 clocks after accept.
- Clipped triangle (-5,-5),(3,-5),(-5,3) -> 16 reads at addresses 0-3, 320-323, 640-643, 960-963; writes match.
- triangle_valid_in held high with two triangles -> ready low from first accept through done; second accepted the cycle after done; no read overlaps the first job's writes.
- Assert rst after 4 reads of a 9-pixel job -> next cycle read_en/calc_valid/write_en=0, ready=1; no later writes.
- Collinear (5,5),(6,6),(7,7):
  - With DEGENERATE_CULL_EN: 0 reads, done_out pulses.
  - Without: 9 reads, 9 writes.

Source files
------------

// File: rtl/triangle_pixel_scanner.sv
// triangle_pixel_scanner: read-side driver and write-back sink for pixel_calculator.
// Per triangle: clip the bounding box to the screen, scan it row-major at one
// pixel per clock, hand each buffer word to the calculator READ_LATENCY clocks
// later, and write every calculator result straight back to the buffer.
// Optional build macro DEGENERATE_CULL_EN: zero-area triangles skip the scan.
module triangle_pixel_scanner #(
    parameter int H_RES        = 320,
    parameter int V_RES        = 240,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [127:0]          triangle_in,
    input  logic                  triangle_valid_in,
    output logic                  triangle_ready_out,
    output logic [ADDR_WIDTH-1:0] read_addr_out,
    output logic                  read_en_out,
    input  logic [31:0]           read_data_in,
    output logic [8:0]            calc_x_out,
    output logic [7:0]            calc_y_out,
    output logic [31:0]           calc_pixel_out,
    output logic [127:0]          calc_triangle_out,
    output logic                  calc_valid_out,
    input  logic [8:0]            calc_x_in,
    input  logic [7:0]            calc_y_in,
    input  logic [31:0]           calc_pixel_in,
    input  logic                  calc_valid_in,
    output logic [ADDR_WIDTH-1:0] write_addr_out,
    output logic [31:0]           write_data_out,
    output logic                  write_en_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int CNT_W = $clog2(H_RES * V_RES + 1);
    localparam logic signed [15:0] X_LIM = 16'(H_RES - 1);
    localparam logic signed [15:0] Y_LIM = 16'(V_RES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SETUP2, SCAN, DRAIN, DONE} state_t;
    state_t state;

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [8:0] clip_x(input logic signed [15:0] v);
        if (v < 16'sd0) return 9'd0;
        if (v > X_LIM)  return 9'(X_LIM);
        return 9'(v);
    endfunction

    function automatic logic [7:0] clip_y(input logic signed [15:0] v);
        if (v < 16'sd0) return 8'd0;
        if (v > Y_LIM)  return 8'(Y_LIM);
        return 8'(v);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [8:0] px, input logic [7:0] py);
        return ADDR_WIDTH'({24'd0, py} * H_RES + {23'd0, px});
    endfunction

    // Vertex fields of the latched triangle (colour and depth pass through untouched)
    logic signed [15:0] p1x, p1y, p2x, p2y, p3x, p3y;
    assign p1x = calc_triangle_out[111:96];
    assign p1y = calc_triangle_out[95:80];
    assign p2x = calc_triangle_out[79:64];
    assign p2y = calc_triangle_out[63:48];
    assign p3x = calc_triangle_out[47:32];
    assign p3y = calc_triangle_out[31:16];

    logic signed [15:0] bx_min, bx_max, by_min, by_max;
    logic               box_empty;
    assign bx_min = min3(p1x, p2x, p3x);
    assign bx_max = max3(p1x, p2x, p3x);
    assign by_min = min3(p1y, p2y, p3y);
    assign by_max = max3(p1y, p2y, p3y);
    assign box_empty = (bx_max < 16'sd0) || (bx_min > X_LIM) ||
                       (by_max < 16'sd0) || (by_min > Y_LIM);

`ifdef DEGENERATE_CULL_EN
    logic signed [31:0] area_term, area_q;
    assign area_term = (32'(p2x) - 32'(p1x)) * (32'(p3y) - 32'(p1y)) -
                       (32'(p2y) - 32'(p1y)) * (32'(p3x) - 32'(p1x));
`endif

    // Scan position: x/y is the pixel whose read is on the bus this cycle
    logic [8:0] x, x_lo, x_hi, x_nxt;
    logic [7:0] y, y_hi, y_nxt;
    logic       last_px;

    // Row-major stepping through the clipped box
    always_comb begin
        last_px = (x == x_hi) && (y == y_hi);
        x_nxt   = x + 9'd1;
        y_nxt   = y;
        if (x == x_hi) begin
            x_nxt = x_lo;
            y_nxt = y + 8'd1;
        end
    end

    // Reads in flight or in the calculator; a stray result at zero holds at zero
    logic [CNT_W-1:0] cnt, cnt_nxt;
    always_comb begin
        cnt_nxt = cnt;
        case ({read_en_out, calc_valid_in})
            2'b10:   cnt_nxt = cnt + CNT_W'(1);
            2'b01:   cnt_nxt = (cnt == '0) ? '0 : cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // Job FSM with registered handshake, read and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            triangle_ready_out <= 1'b1;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            read_en_out        <= 1'b0;
            read_addr_out      <= '0;
            calc_triangle_out  <= '0;
            x                  <= '0;
            y                  <= '0;
            x_lo               <= '0;
            x_hi               <= '0;
            y_hi               <= '0;
            cnt                <= '0;
`ifdef DEGENERATE_CULL_EN
            area_q             <= '0;
`endif
        end else begin
            cnt      <= cnt_nxt;
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (triangle_valid_in) begin
                        calc_triangle_out  <= triangle_in;
                        triangle_ready_out <= 1'b0;
                        busy_out           <= 1'b1;
                        state              <= SETUP;
                    end
                end
                SETUP, SETUP2: begin
`ifdef DEGENERATE_CULL_EN
                    // First setup cycle only registers the area product
                    if (state == SETUP) begin
                        area_q <= area_term;
                        state  <= SETUP2;
                    end else if (box_empty || area_q == '0) begin
`else
                    if (box_empty) begin
`endif
                        done_out <= 1'b1;
                        state    <= DONE;
                    end else begin
                        x             <= clip_x(bx_min);
                        x_lo          <= clip_x(bx_min);
                        x_hi          <= clip_x(bx_max);
                        y             <= clip_y(by_min);
                        y_hi          <= clip_y(by_max);
                        read_en_out   <= 1'b1;
                        read_addr_out <= pix_addr(clip_x(bx_min), clip_y(by_min));
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (last_px) begin
                        read_en_out <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        x             <= x_nxt;
                        y             <= y_nxt;
                        read_addr_out <= pix_addr(x_nxt, y_nxt);
                    end
                end
                DRAIN: begin
                    if (cnt == '0 && !read_en_out) begin
                        done_out <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    triangle_ready_out <= 1'b1;
                    busy_out           <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Coordinates ride alongside the read so they meet the returning word
    logic [READ_LATENCY:1]       vld_pipe;
    logic [READ_LATENCY:1][8:0]  x_pipe;
    logic [READ_LATENCY:1][7:0]  y_pipe;

    // Delay line matching the buffer read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            x_pipe   <= '0;
            y_pipe   <= '0;
        end else begin
            vld_pipe[1] <= read_en_out;
            x_pipe[1]   <= x;
            y_pipe[1]   <= y;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                x_pipe[i]   <= x_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
            end
        end
    end

    assign calc_valid_out = vld_pipe[READ_LATENCY];
    assign calc_x_out     = x_pipe[READ_LATENCY];
    assign calc_y_out     = y_pipe[READ_LATENCY];
    assign calc_pixel_out = read_data_in;

    // Results go straight back to the buffer in the cycle they arrive
    assign write_en_out   = calc_valid_in;
    assign write_addr_out = pix_addr(calc_x_in, calc_y_in);
    assign write_data_out = calc_pixel_in;

endmodule
